csr_spi_bridge: RTL and testbench
=================================

# csr_spi_bridge

SPI-slave bridge that acts as the bus master for the CSR block: it turns serial command frames from the host MCU into CSR byte accesses on the 12-bit address / 8-bit data memory interface. It sits directly upstream of the CSR block, driving its address, write strobe and write data, and capturing its registered read data. Bursts auto-increment the address so a whole volume table or U/C-data window can be streamed in one frame.

## Interface
- SYNC_STAGES, 2, flip-flop stages on each SPI input (sck, mosi, ss_n) before edge detection; minimum 2
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- spi_sck_i  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- spi_mosi_i  in  1  host→bridge data, MSB first
- spi_ss_n_i  in  1  slave select, active low; frames one transaction
- spi_miso_o  out  1  bridge→host data, MSB first
- addr_o  out  12  CSR address
- ack_o  out  1  one-cycle write strobe
- data_o  out  8  CSR write data, valid while ack_o=1
- data_i  in  8  CSR read data; valid 1 cycle after addr_o changes (registered in CSR)
- busy_o  out  1  synchronized ss_n low, i.e. frame in progress

## Operation
- Frame: byte 0 = {rw, 3'b000, addr[11:8]} (rw=1 read); byte 1 = addr[7:0]; bytes 2.. = data. Bits [6:4] of byte 0 are ignored.
- States: IDLE → CMD (on synced ss_n falling) → ADDR (byte 0 done) → WDATA (byte 1 done, rw=0) or RDATA (byte 1 done, rw=1). Synced ss_n high in any state → IDLE, bit counter cleared, partial byte discarded, no ack_o.
- Bit capture: mosi (synced, same delay as sck) shifted into rx register on each detected sck rising edge; 3-bit counter; byte complete at 8th rising edge (cycle T).
- ADDR done at T: addr_o <= {cmd[3:0], rx} visible at T+1.
- WDATA byte done at T: ack_o=1, data_o=byte, addr_o unchanged in T+1; addr_o <= addr_o+1 visible at T+2.
- RDATA: after ADDR byte or each read data byte done at T: addr_o updated (to start address, or +1) at T+1; data_i sampled in T+2 into tx register. No ack_o ever issued for reads.
- Address increment wraps 12'hfff → 12'h000; no error.
- MISO: spi_miso_o = tx[7]. tx shifts left on detected sck falling edge only when bit counter ≠ 0 (the falling edge after bit 8 presents the freshly loaded MSB). tx cleared to 0 during CMD/ADDR and on entering IDLE, so miso reads 0 outside read data.
- First read data byte returns contents of start address; each further byte returns the next address.
- Reads have no side effect on CSR beyond addressing; a trailing prefetch at frame end is harmless.

## Timing
- Reset values: addr_o=0, ack_o=0, data_o=0, spi_miso_o=0, busy_o=0, state IDLE, counters 0.
- Input latency: SYNC_STAGES + 1 edge-detect cycle from pin to detected edge.
- Write latency: ack_o asserted exactly 1 cycle after 8th detected rising edge of the data byte; exactly one pulse per complete byte.
- Read path: tx loaded 3 cycles after byte completion; must precede next detected sck falling edge. Requirement: f_clk ≥ 8 × f_sck with ~50% sck duty; bench verifies at this ratio.
- ss_n rise coincident with 8th rising edge detection: byte counts as complete (edge processed first), then IDLE.
- rst mid-frame: all state cleared next cycle; bridge waits for a fresh ss_n falling edge (ss_n already low at reset release does not start a frame).

## Test plan
- Write burst: cmd 0x00, addr 0x00, data 0x12,0x34 → ack_o pulses with (addr 0x000, 0x12) then (0x001, 0x34); no other acks.
- Read: CSR model returns addr[7:0]^0x5A; frame cmd 0x84, addr 0x00, 3 dummy bytes → MISO bytes 0x5A,0x5B,0x58; addr_o 0x400..0x403; ack_o never high.
- Wrap: write cmd 0x0F, addr 0xFF, data 0xAA,0xBB → acks at 0xFFF then 0x000.
- Abort: ss_n rises after 5 bits of a write data byte → no ack; next frame writing 0x77 to 0x600 acks normally.
- Reset mid-read-frame with ss_n held low → outputs return to reset values; no activity until ss_n cycles high→low.
- Min ratio: f_clk = 8 × f_sck, read of 16 bytes from 0x500 → all bytes match model, no bit slip.

Source files
------------

// File: rtl/csr_spi_bridge.sv
// csr_spi_bridge: SPI mode-0 slave that masters CSR byte accesses (ports: clk, rst, spi_sck_i/mosi_i/ss_n_i in, spi_miso_o out, addr_o/ack_o/data_o to CSR, data_i from CSR, busy_o frame in progress)
module csr_spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck_i,
  input  logic        spi_mosi_i,
  input  logic        spi_ss_n_i,
  output logic        spi_miso_o,
  output logic [11:0] addr_o,
  output logic        ack_o,
  output logic [7:0]  data_o,
  input  logic [7:0]  data_i,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sck_q, mosi_q, ss_q;
  logic sck_d, ss_d;
  logic sck_s, mosi_s, ss_s, rise, fall, ss_fall, done;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] byte_v, tx;
  logic [4:0] cmd;
  logic rd1, rd2;
  // ss chain resets low so an ss_n already low at reset release never looks like a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      mosi_q <= '0;
      ss_q <= '0;
      sck_d <= 1'b0;
      ss_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck_i};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
      ss_q <= {ss_q[SYNC_STAGES-2:0], spi_ss_n_i};
      sck_d <= sck_s;
      ss_d <= ss_s;
    end
  end
  assign sck_s = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign rise = sck_s & ~sck_d;
  assign fall = ~sck_s & sck_d;
  assign ss_fall = ss_d & ~ss_s;
  assign byte_v = {rx, mosi_s};
  assign done = (state != IDLE) && rise && (cnt == 3'd7);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // a byte completing together with ss_n rising is still processed by the datapath
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = ss_fall ? CMD : IDLE;
    else if (ss_s) state_n = IDLE;
    else if (done && state == CMD) state_n = ADDR;
    else if (done && state == ADDR) state_n = cmd[4] ? RDATA : WDATA;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rx <= '0;
      cmd <= '0;
      addr_o <= '0;
      ack_o <= 1'b0;
      data_o <= '0;
      tx <= '0;
      rd1 <= 1'b0;
      rd2 <= 1'b0;
    end else begin
      ack_o <= done && state == WDATA;
      rd1 <= done && (state == RDATA || (state == ADDR && cmd[4]));
      rd2 <= rd1;
      if (done && state == WDATA) data_o <= byte_v;
      if (done && state == CMD) cmd <= {byte_v[7], byte_v[3:0]};
      // writes bump the address the cycle after the strobe, reads right after the byte
      if (done && state == ADDR) addr_o <= {cmd[3:0], byte_v};
      else if (ack_o || (done && state == RDATA)) addr_o <= addr_o + 12'd1;
      if (state == IDLE || ss_s) cnt <= '0;
      else if (rise) begin
        cnt <= cnt + 3'd1;
        rx <= byte_v[6:0];
      end
      // rd2 marks the cycle where data_i reflects the freshly driven address
      if (state != RDATA || ss_s) tx <= '0;
      else if (rd2) tx <= data_i;
      else if (fall && cnt != 3'd0) tx <= {tx[6:0], 1'b0};
    end
  end
  assign spi_miso_o = tx[7];
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_csr_spi_bridge.sv
// tb_csr_spi_bridge: scoreboard bench for csr_spi_bridge at f_clk = 8 x f_sck
module tb_csr_spi_bridge;
  logic clk = 0, rst = 1;
  logic spi_sck_i = 0, spi_mosi_i = 0, spi_ss_n_i = 1;
  logic spi_miso_o, ack_o, busy_o;
  logic [11:0] addr_o;
  logic [7:0] data_o, data_i;
  int checks = 0, errors = 0;
  logic [19:0] exp_wr[$];
  logic [7:0] exp_rd[$], rx_seen[$], fb[$];

  csr_spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sck_i(spi_sck_i), .spi_mosi_i(spi_mosi_i),
    .spi_ss_n_i(spi_ss_n_i), .spi_miso_o(spi_miso_o), .addr_o(addr_o),
    .ack_o(ack_o), .data_o(data_o), .data_i(data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) data_i <= addr_o[7:0] ^ 8'h5A;

  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst && ack_o) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got addr=%h data=%h, required no ack", addr_o, data_o);
      end else begin
        e = exp_wr.pop_front();
        if ({addr_o, data_o} !== e) begin
          errors++;
          $display("FAIL write_ack: got addr=%h data=%h, required addr=%h data=%h", addr_o, data_o, e[19:8], e[7:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [7:0] g, e;
    if (rx_seen.size() != 0) begin
      g = rx_seen.pop_front();
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL extra_read_byte: got %h, required none", g);
      end else begin
        e = exp_rd.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL miso_byte: got %h, required %h", g, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, a, e);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r, input int nbits);
    r = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi_i = b[i];
      #40;
      r[i] = spi_miso_o;
      spi_sck_i = 1;
      #40;
      spi_sck_i = 0;
    end
  endtask

  task automatic frame(input bit rd);
    logic [7:0] r;
    @(negedge clk);
    spi_ss_n_i = 0;
    #40;
    chk("busy_in_frame", busy_o, 1);
    foreach (fb[i]) begin
      spi_byte(fb[i], r, 8);
      if (rd && i >= 2) rx_seen.push_back(r);
    end
    #40;
    spi_ss_n_i = 1;
    #120;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_addr", addr_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_miso", spi_miso_o, 0);
    chk("rst_busy", busy_o, 0);
    exp_wr.push_back({12'h000, 8'h12});
    exp_wr.push_back({12'h001, 8'h34});
    fb = {8'h00, 8'h00, 8'h12, 8'h34};
    frame(0);
    chk("wr_addr_after", addr_o, 12'h002);
    chk("idle_busy", busy_o, 0);
    exp_rd = {8'h5A, 8'h5B, 8'h58};
    fb = {8'h84, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(1);
    chk("rd_addr_after", addr_o, 12'h403);
    chk("rd_miso_idle", spi_miso_o, 0);
    exp_wr.push_back({12'hFFF, 8'hAA});
    exp_wr.push_back({12'h000, 8'hBB});
    fb = {8'h0F, 8'hFF, 8'hAA, 8'hBB};
    frame(0);
    chk("wrap_addr_after", addr_o, 12'h001);
    @(negedge clk);
    spi_ss_n_i = 0;
    #40;
    spi_byte(8'h00, r, 8);
    spi_byte(8'h10, r, 8);
    spi_byte(8'hCC, r, 5);
    #40;
    spi_ss_n_i = 1;
    #120;
    chk("abort_busy", busy_o, 0);
    chk("abort_addr", addr_o, 12'h010);
    exp_wr.push_back({12'h600, 8'h77});
    fb = {8'h06, 8'h00, 8'h77};
    frame(0);
    chk("after_abort_addr", addr_o, 12'h601);
    @(negedge clk);
    spi_ss_n_i = 0;
    #40;
    spi_byte(8'h85, r, 8);
    spi_byte(8'h00, r, 8);
    spi_byte(8'h00, r, 3);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midrst_addr", addr_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_miso", spi_miso_o, 0);
    chk("midrst_ack", ack_o, 0);
    chk("midrst_data", data_o, 0);
    spi_byte(8'h01, r, 8);
    spi_byte(8'h23, r, 8);
    spi_byte(8'h45, r, 8);
    chk("held_ss_busy", busy_o, 0);
    chk("held_ss_addr", addr_o, 0);
    spi_ss_n_i = 1;
    #80;
    fb = {8'h85, 8'h00};
    for (int i = 0; i < 16; i++) begin
      exp_rd.push_back(8'(i) ^ 8'h5A);
      fb.push_back(8'hFF);
    end
    frame(1);
    chk("burst_addr_after", addr_o, 12'h510);
    chk("burst_miso_idle", spi_miso_o, 0);
    repeat (50) begin
      if (exp_wr.size() == 0 && exp_rd.size() == 0 && rx_seen.size() == 0) break;
      @(negedge clk);
    end
    chk("wr_leftover", exp_wr.size(), 0);
    chk("rd_leftover", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
